// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state enumeration and a helper that maps a size code to the
// number of bytes touched by the access.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // Controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        STORE  = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    // Number of bytes covered by an access of the given size
    function automatic logic [3:0] byte_count(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SIZE_B:  n = 4'd1;
            SIZE_H:  n = 4'd2;
            SIZE_W:  n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational lane logic for the load/store unit. Memory is
// big-endian, so the addressed byte always sits in bits 63:56 of the
// doubleword returned for that address.
//   i_rdata      : doubleword read from memory at the access address
//   i_wdata      : store data (payload right-aligned in the low bits)
//   i_size       : access size code
//   i_unsigned   : zero-extend narrow loads instead of sign-extending
//   o_load_data  : extracted and extended load result
//   o_merge_data : i_rdata with its top bytes replaced by the store payload
// -----------------------------------------------------------------------------
module load_store_unit_lsu_byte_lane_dummy_unused;
endmodule

module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_load_data,
    output logic [63:0] o_merge_data
);

    // Extract/extend the load value and build the read-modify-write word
    always_comb begin
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        case (i_size)
            SIZE_B: begin
                if (i_unsigned) begin
                    o_load_data = {56'd0, i_rdata[63:56]};
                end else begin
                    o_load_data = {{56{i_rdata[63]}}, i_rdata[63:56]};
                end
                o_merge_data = {i_wdata[7:0], i_rdata[55:0]};
            end
            SIZE_H: begin
                if (i_unsigned) begin
                    o_load_data = {48'd0, i_rdata[63:48]};
                end else begin
                    o_load_data = {{48{i_rdata[63]}}, i_rdata[63:48]};
                end
                o_merge_data = {i_wdata[15:0], i_rdata[47:0]};
            end
            SIZE_W: begin
                if (i_unsigned) begin
                    o_load_data = {32'd0, i_rdata[63:32]};
                end else begin
                    o_load_data = {{32{i_rdata[63]}}, i_rdata[63:32]};
                end
                o_merge_data = {i_wdata[31:0], i_rdata[31:0]};
            end
            default: begin
                // Doubleword: no extension, the unsigned flag has no effect
                o_load_data  = i_rdata;
                o_merge_data = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store controller in front of a 64-bit big-endian
// memory with combinational read and synchronous write. Narrow stores are
// done as read-modify-write of the doubleword at the access address.
// Optional build macro: LSU_ALIGN_CHECK_EN -- when defined, a request whose
// address is not a multiple of its access size is answered immediately with
// resp_misaligned=1 and never touches memory.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_misaligned
//   MemRead, MemWrite, mem_addr, mem_wdata, mem_rdata
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [63:0]       r_wdata;     // store payload, becomes merged word in RMW
    logic              r_resp_valid;
    logic [63:0]       r_rdata;
    logic              r_misaligned;

    logic [63:0]       w_load_data;
    logic [63:0]       w_merge_data;
    logic              w_misaligned;

`ifdef LSU_ALIGN_CHECK_EN
    logic [3:0]        w_align_mask;
    assign w_align_mask = byte_count(req_size) - 4'd1;
    assign w_misaligned = |(req_addr[2:0] & w_align_mask[2:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Memory strobes are a pure decode of the state register so reset drops them at once
    assign MemRead         = (r_state == LOAD) || (r_state == RMW_RD);
    assign MemWrite        = (r_state == RMW_WR) || (r_state == STORE);
    assign req_ready       = reset && (r_state == IDLE);
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_rdata;
    assign resp_misaligned = r_misaligned;

    // Request sequencing FSM with registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= 64'd0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 64'd0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_rdata    <= 64'd0;
                        if (w_misaligned) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else if (!req_we) begin
                            r_state <= LOAD;
                        end else if (req_size == SIZE_D) begin
                            r_state <= STORE;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_rdata      <= w_load_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RMW_RD: begin
                    // Old doubleword is merged here so the write cycle drives a register
                    r_wdata <= w_merge_data;
                    r_state <= RMW_WR;
                end
                RMW_WR, STORE: begin
                    r_rdata      <= 64'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_misaligned <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
